// File: rtl/sdram_read_scoreboard.sv
// In-order read-data checker for the SDRAM exerciser: tracks accepted read addresses in a
// small FIFO and checks each returned word against ~addr. The first failure is latched sticky.
module sdram_read_scoreboard #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issueValid,
  input  logic [ADDR_W-1:0]          issueAddr,
  input  logic                       rdValid,
  input  logic [DATA_W-1:0]          rdData,
  output logic                       canIssue,
  output logic [$clog2(DEPTH):0]     pending,
  output logic                       ok,
  output logic [1:0]                 failCode,
  output logic [ADDR_W-1:0]          failAddr,
  output logic [DATA_W-1:0]          failData,
  output logic [CNT_W-1:0]           checkedCount,
  output logic [CNT_W-1:0]           errCount
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int PEND_W = PTR_W + 1;
  localparam logic [PEND_W-1:0] FULL = PEND_W'(DEPTH);

  typedef enum logic [1:0] {
    FC_NONE  = 2'd0,
    FC_MISM  = 2'd1,
    FC_UNDER = 2'd2,
    FC_OVER  = 2'd3
  } fail_e;

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              ok_q, ok_d;
  fail_e             code_q, code_d, code_now;
  logic [ADDR_W-1:0] faddr_q, faddr_d, faddr_now;
  logic [DATA_W-1:0] fdata_q, fdata_d, fdata_now;
  logic [CNT_W-1:0]  chk_q, chk_d, err_q, err_d;
  logic              push, pop, under, over, mism, fail;
  logic [ADDR_W-1:0] head;
  logic [DATA_W-1:0] exp_data;

  always_comb begin
    head     = mem[rptr_q];
    exp_data = ~DATA_W'(head);
    // A full FIFO still accepts an issue when a pop frees the head slot in the same cycle.
    push  = issueValid && (pending_q != FULL || rdValid);
    pop   = rdValid && (pending_q != '0);
    under = rdValid && (pending_q == '0);
    over  = issueValid && (pending_q == FULL) && !rdValid;
    mism  = pop && (rdData != exp_data);
    fail  = under || over || mism;

    code_now  = FC_NONE;
    faddr_now = '0;
    fdata_now = '0;
    if (mism) begin
      code_now  = FC_MISM;
      faddr_now = head;
      fdata_now = rdData;
    end else if (under) begin
      code_now  = FC_UNDER;
      fdata_now = rdData;
    end else if (over) begin
      code_now  = FC_OVER;
      faddr_now = issueAddr;
    end

    wptr_d    = wptr_q + PTR_W'(push);
    rptr_d    = rptr_q + PTR_W'(pop);
    pending_d = pending_q + PEND_W'(push) - PEND_W'(pop);
    chk_d     = chk_q + CNT_W'(pop);
    err_d     = (fail && err_q != '1) ? err_q + CNT_W'(1) : err_q;

    ok_d    = ok_q;
    code_d  = code_q;
    faddr_d = faddr_q;
    fdata_d = fdata_q;
    if (fail && ok_q) begin
      ok_d    = 1'b0;
      code_d  = code_now;
      faddr_d = faddr_now;
      fdata_d = fdata_now;
    end
  end

  // Storage needs no reset: pending gates every read of it.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wptr_q] <= issueAddr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      pending_q <= '0;
      ok_q      <= 1'b1;
      code_q    <= FC_NONE;
      faddr_q   <= '0;
      fdata_q   <= '0;
      chk_q     <= '0;
      err_q     <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      pending_q <= pending_d;
      ok_q      <= ok_d;
      code_q    <= code_d;
      faddr_q   <= faddr_d;
      fdata_q   <= fdata_d;
      chk_q     <= chk_d;
      err_q     <= err_d;
    end
  end

  assign canIssue     = (pending_q != FULL);
  assign pending      = pending_q;
  assign ok           = ok_q;
  assign failCode     = code_q;
  assign failAddr     = faddr_q;
  assign failData     = fdata_q;
  assign checkedCount = chk_q;
  assign errCount     = err_q;
endmodule

// File: tb/tb_sdram_read_scoreboard.sv
// Scoreboard bench: a queue-based reference model predicts the full output state per cycle,
// and an independent negedge monitor compares it against the DUT.
module tb_sdram_read_scoreboard;
  localparam int ADDR_W = 8, DATA_W = 8, DEPTH = 4, CNT_W = 16;

  logic clk = 1'b0;
  logic rst, issueValid, rdValid;
  logic [ADDR_W-1:0] issueAddr;
  logic [DATA_W-1:0] rdData;
  logic canIssue, ok;
  logic [2:0] pending;
  logic [1:0] failCode;
  logic [ADDR_W-1:0] failAddr;
  logic [DATA_W-1:0] failData;
  logic [CNT_W-1:0] checkedCount, errCount;

  always #5 clk = ~clk;

  sdram_read_scoreboard #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .issueValid(issueValid), .issueAddr(issueAddr),
    .rdValid(rdValid), .rdData(rdData), .canIssue(canIssue), .pending(pending),
    .ok(ok), .failCode(failCode), .failAddr(failAddr), .failData(failData),
    .checkedCount(checkedCount), .errCount(errCount)
  );

  typedef struct packed {
    logic [2:0]  pend;
    logic        can;
    logic        ok;
    logic [1:0]  code;
    logic [7:0]  fa;
    logic [7:0]  fd;
    logic [15:0] chk;
    logic [15:0] err;
  } snap_t;

  snap_t exp_q[$];
  int n_checks = 0, n_pass = 0;

  // Reference model state
  logic [7:0]  mq[$];
  logic        m_ok;
  logic [1:0]  m_code;
  logic [7:0]  m_fa, m_fd;
  logic [15:0] m_chk, m_err;

  task automatic model_reset();
    mq.delete();
    m_ok = 1'b1; m_code = 2'd0; m_fa = '0; m_fd = '0; m_chk = '0; m_err = '0;
  endtask

  task automatic model_fail(input logic [1:0] c, input logic [7:0] a, input logic [7:0] d);
    if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
    if (m_ok) begin
      m_ok = 1'b0; m_code = c; m_fa = a; m_fd = d;
    end
  endtask

  task automatic model_step(input bit iv, input logic [7:0] ia, input bit rv, input logic [7:0] rd);
    int n0;
    logic [7:0] h;
    n0 = mq.size();
    if (rv) begin
      if (n0 == 0) model_fail(2'd2, 8'h00, rd);
      else begin
        h = mq.pop_front();
        m_chk = m_chk + 16'd1;
        if (rd != ~DATA_W'(h)) model_fail(2'd1, h, rd);
      end
    end
    if (iv) begin
      if (n0 == DEPTH && !rv) model_fail(2'd3, ia, 8'h00);
      else mq.push_back(ia);
    end
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.pend = 3'(mq.size());
    s.can  = (mq.size() < DEPTH);
    s.ok = m_ok; s.code = m_code; s.fa = m_fa; s.fd = m_fd;
    s.chk = m_chk; s.err = m_err;
    return s;
  endfunction

  // One clock of stimulus; the predicted post-edge state goes to the scoreboard queue.
  task automatic cycle(input bit r, input bit iv, input logic [7:0] ia, input bit rv, input logic [7:0] rd);
    rst = r; issueValid = iv; issueAddr = ia; rdValid = rv; rdData = rd;
    if (r) model_reset();
    else model_step(iv, ia, rv, rd);
    @(posedge clk);
    exp_q.push_back(model_snap());
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    snap_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.pend = pending; a.can = canIssue; a.ok = ok; a.code = failCode;
      a.fa = failAddr; a.fd = failData; a.chk = checkedCount; a.err = errCount;
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL state @%0t: got pend=%0d can=%0b ok=%0b code=%0d fa=%h fd=%h chk=%0d err=%0d, want pend=%0d can=%0b ok=%0b code=%0d fa=%h fd=%h chk=%0d err=%0d",
                    $time, a.pend, a.can, a.ok, a.code, a.fa, a.fd, a.chk, a.err,
                    e.pend, e.can, e.ok, e.code, e.fa, e.fd, e.chk, e.err);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit iv, rv;
    logic [7:0] a, d;
    rst = 1'b1; issueValid = 1'b0; issueAddr = '0; rdValid = 1'b0; rdData = '0;
    model_reset();
    @(negedge clk); #1;
    cycle(1, 0, 8'h00, 0, 8'h00);

    // In-order correct returns
    cycle(0, 1, 8'h10, 0, 8'h00);
    cycle(0, 1, 8'h20, 0, 8'h00);
    cycle(0, 1, 8'h30, 0, 8'h00);
    cycle(0, 0, 8'h00, 1, 8'hEF);
    cycle(0, 0, 8'h00, 1, 8'hDF);
    cycle(0, 0, 8'h00, 1, 8'hCF);

    // Mismatch, then frozen capture while a correct read goes through
    cycle(1, 0, 8'h00, 0, 8'h00);
    cycle(0, 1, 8'h05, 0, 8'h00);
    cycle(0, 0, 8'h00, 1, 8'h00);
    cycle(0, 1, 8'h40, 0, 8'h00);
    cycle(0, 0, 8'h00, 1, 8'hBF);

    // Underflow with a same-cycle issue; the push still lands
    cycle(1, 0, 8'h00, 0, 8'h00);
    cycle(0, 1, 8'h07, 1, 8'hAA);
    cycle(0, 0, 8'h00, 1, 8'hF8);

    // Fill, overflow, then a legal push+pop while full
    cycle(1, 0, 8'h00, 0, 8'h00);
    for (int i = 1; i <= 4; i++) cycle(0, 1, 8'(i), 0, 8'h00);
    cycle(0, 1, 8'h55, 0, 8'h00);
    cycle(0, 1, 8'h66, 1, 8'hFE);
    for (int i = 0; i < 4; i++) cycle(0, 0, 8'h00, 1, ~mq[0]);

    // Long clean random run: pointers wrap many times
    cycle(1, 0, 8'h00, 0, 8'h00);
    for (int i = 0; i < 1000; i++) begin
      rv = ($urandom_range(0, 1) == 1) && (mq.size() > 0);
      iv = ($urandom_range(0, 1) == 1) && (mq.size() < DEPTH || rv);
      a  = 8'($urandom);
      d  = rv ? ~mq[0] : 8'($urandom);
      cycle(0, iv, a, rv, d);
    end

    // Unconstrained random run: errors of every kind plus occasional resets
    for (int i = 0; i < 600; i++) begin
      iv = ($urandom_range(0, 2) != 0);
      rv = ($urandom_range(0, 2) == 0);
      a  = 8'($urandom);
      d  = (mq.size() > 0 && $urandom_range(0, 3) != 0) ? ~mq[0] : 8'($urandom);
      cycle(($urandom_range(0, 59) == 0), iv, a, rv, d);
    end

    // Reset with reads in flight, then a stale return
    cycle(1, 0, 8'h00, 0, 8'h00);
    cycle(0, 1, 8'h11, 0, 8'h00);
    cycle(0, 1, 8'h22, 0, 8'h00);
    cycle(0, 1, 8'h33, 0, 8'h00);
    cycle(1, 0, 8'h00, 0, 8'h00);
    cycle(0, 0, 8'h00, 1, 8'hEE);

    rst = 1'b0; issueValid = 1'b0; rdValid = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d predictions left unchecked, want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sdram_read_scoreboard.md
# sdram_read_scoreboard

Downstream checker for the SDRAM random read/write exerciser: tracks every read command the controller accepts, pairs each returned read word with its issuing address in order, and checks the data against the address-derived pattern (bitwise NOT of the address). It replaces ad-hoc shift-register bookkeeping in test tops. It raises a sticky failure with captured diagnostics that drives the red LED. It also exports a back-pressure flag so the traffic generator never has more reads in flight than the scoreboard can hold.

## Interface
- ADDR_W, 8, width of tracked read address
- DATA_W, 8, width of read data; expected data = ~(addr zero-extended to DATA_W)
- DEPTH, 4, max outstanding reads; power of two, >= 2
- CNT_W, 16, width of checkedCount and errCount
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- issueValid  in  1  a read command was accepted this cycle (cmdTrigger && cmdReady && !cmdWrite)
- issueAddr  in  ADDR_W  address of that read
- rdValid  in  1  controller read data valid
- rdData  in  DATA_W  controller read data
- canIssue  out  1  pending < DEPTH; combinational from the pending register only
- pending  out  $clog2(DEPTH)+1  reads in flight
- ok  out  1  1 until the first failure, then 0 until rst
- failCode  out  2  0 none, 1 mismatch, 2 underflow (data with nothing pending), 3 overflow (issue while full)
- failAddr  out  ADDR_W  address associated with the first failure
- failData  out  DATA_W  rdData at the first failure (0 for overflow)
- checkedCount  out  CNT_W  read words compared; wraps
- errCount  out  CNT_W  total failures of any kind; saturates at all-ones

## Operation
- Circular FIFO of DEPTH addresses, with write pointer, read pointer and pending count. Pointers are $clog2(DEPTH) bits and wrap naturally.
- Push: issueValid and (pending < DEPTH or rdValid). The address is stored at the write pointer.
- Pop: rdValid and pending > 0. Head address H is read, and rdData is compared with ~H.
- Simultaneous push and pop: both occur and pending is unchanged. This is also legal when full.
- Underflow: rdValid with pending == 0. Counts as underflow even if issueValid is high the same cycle, since same-cycle return is impossible. The push still occurs. failAddr = 0.
- Overflow: issueValid, pending == DEPTH, and no pop. The push is dropped and the FIFO is unchanged. failAddr = issueAddr.
- Mismatch: pop with rdData != ~H. failAddr = H, failData = rdData. The entry is popped regardless of the compare result.
- The three failure kinds are mutually exclusive within a cycle, so at most one fires per cycle.
- checkedCount increments on every pop, whether it matches or not. Underflow does not increment it.
- errCount increments on every failure, including failures after the first.
- First failure, i.e. while ok == 1:
  - ok <= 0.
  - failCode, failAddr and failData are captured.
  - The captured values are frozen thereafter until rst.
- The FIFO and counters keep operating after a failure. ok never returns to 1 without rst.
- rst mid-operation: all in-flight entries are discarded. Any read data returned after reset with nothing pending is reported as underflow. Upstream must reset together with the controller.

## Timing
- Reset values:
  - ok = 1, canIssue = 1.
  - pending = 0, failCode = 0, failAddr = 0, failData = 0, checkedCount = 0, errCount = 0.
  - Both pointers = 0.
- All outputs are registered except canIssue.
- Latency: an event sampled at edge N is reflected in pending, ok, fail* and the counters after edge N.
- canIssue is valid in the same cycle as the pending register update. It drops in the cycle after the push that fills the FIFO.
- No combinational path exists from issueValid, rdValid or rdData to any output.
- An entry pushed at edge N is poppable from edge N+1 onward. Controller read latency is at least 2, so this is never binding.

## Test plan
- Reset, then issue reads 0x10, 0x20, 0x30; return 0xEF, 0xDF, 0xCF -> ok=1, checkedCount=3, pending ends 0, errCount=0.
- Issue 0x05; return 0x00 -> ok=0, failCode=1, failAddr=0x05, failData=0x00, errCount=1. Then issue and return a correct read -> capture regs unchanged, checkedCount=2.
- Pulse rdValid (data 0xAA) with pending=0, issueValid=1 same cycle, addr 0x07 -> failCode=2, failAddr=0, pending=1.
- DEPTH=4: issue 4 reads -> canIssue=0. A 5th issue with no rdValid -> failCode=3, failAddr=5th address, pending stays 4. A 5th issue with a concurrent correct rdValid -> no fail, pending 4.
- Wrap-around: 1000 random interleaved issues and returns, keeping pending <= 4 and data correct -> ok=1, checkedCount=number of returns, pointers wrap with no error.
- Assert rst with pending=3 -> all outputs at reset values next cycle. A stale rdValid after that -> underflow, errCount=1.
